// File: rtl/audio_pll_lock_sequencer.sv
// audio_pll_lock_sequencer
//   Supervises the audio PLL from the reference-clock domain. It pulses the
//   PLL reset, waits for a stable synchronized lock, and only then releases
//   the audio-clock logic reset. A lock timeout causes a retry. After
//   MAX_RETRIES retries the block enters a sticky FAULT state. Loss of lock
//   or a software relock request in RUN starts the whole sequence again.
//
// Ports
//   refclk      in   reference clock (the only clock)
//   rst         in   asynchronous active-high reset
//   pll_locked  in   PLL lock indicator, asynchronous to refclk
//   relock_req  in   relock / fault-clear request
//   pll_rst     out  reset to the PLL
//   audio_rst   out  audio-clock logic reset (consumer syncs deassertion)
//   ready       out  high while in RUN
//   fault       out  high while in FAULT
//   retry_count out  retries used in the current sequence
//   state_dbg   out  encoded FSM state (RESET_PLL=0 .. FAULT=4)
//
// Request semantics: relock_req is a single-cycle pulse sampled on refclk.
// There is no ready/acknowledge. It takes effect only in RUN (relock) or
// FAULT (clear and restart). In every other state it is dropped silently.

module audio_pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 17
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       audio_rst,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [1:0]       retry_n;
  logic             sync1;
  logic             lk;

  // Two-flop synchronizer for the asynchronous lock indicator.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
    end
  end

  // Next-state logic. One shared counter serves each state. Every terminal
  // compare clears it, so the counter never wraps.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    retry_n = retry_count;
    case (state)
      S_RESET_PLL: begin
        if (cnt == RST_LAST) begin
          state_n = S_WAIT_LOCK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        // Lock wins over a timeout that lands on the same cycle.
        if (lk) begin
          state_n = S_STABILIZE;
          cnt_n   = '0;
        end else if (cnt == TO_LAST) begin
          cnt_n = '0;
          if (retry_count < RETRY_MAX) begin
            retry_n = retry_count + 2'd1;
            state_n = S_RESET_PLL;
          end else begin
            state_n = S_FAULT;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_STABILIZE: begin
        // A lock glitch restarts the timeout window without using a retry.
        if (!lk) begin
          state_n = S_WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_RUN: begin
        if (!lk || relock_req) begin
          state_n = S_RESET_PLL;
          cnt_n   = '0;
          retry_n = 2'd0;
        end
      end
      S_FAULT: begin
        if (relock_req) begin
          state_n = S_RESET_PLL;
          cnt_n   = '0;
          retry_n = 2'd0;
        end
      end
      default: begin
        state_n = S_RESET_PLL;
        cnt_n   = '0;
        retry_n = 2'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state, so each registered output
  // changes on the same edge as the state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state       <= S_RESET_PLL;
      cnt         <= '0;
      retry_count <= 2'd0;
      pll_rst     <= 1'b1;
      audio_rst   <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      retry_count <= retry_n;
      pll_rst     <= (state_n == S_RESET_PLL) || (state_n == S_FAULT);
      audio_rst   <= (state_n != S_RUN);
      ready       <= (state_n == S_RUN);
      fault       <= (state_n == S_FAULT);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_audio_pll_lock_sequencer.sv
// tb_audio_pll_lock_sequencer
//   Bench for audio_pll_lock_sequencer with small parameters (pulse 4,
//   stable 8, timeout 32, 2 retries). Each scenario task pushes the state
//   sequence it expects onto exp_q. A negedge monitor pops and compares one
//   entry each time state_dbg changes. The tasks also check timing inline.

module tb_audio_pll_lock_sequencer;

  localparam int RP       = 4;
  localparam int LS       = 8;
  localparam int LT       = 32;
  localparam int MR       = 2;
  localparam int CW       = 6;
  localparam int LOCK_LAT = 2 + LS + 1;

  localparam int SEL_PLL  = 0;
  localparam int SEL_AUD  = 1;
  localparam int SEL_RDY  = 2;
  localparam int SEL_FLT  = 3;
  localparam int SEL_STAB = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       audio_rst;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [2:0] state_dbg;

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [2:0] exp_q[$];
  logic [2:0] prev_state = 3'd0;
  logic [2:0] sb_exp;
  logic       mon_en = 1'b0;

  audio_pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (RP),
    .LOCK_STABLE_CYCLES (LS),
    .LOCK_TIMEOUT_CYCLES(LT),
    .MAX_RETRIES        (MR),
    .CNT_W              (CW)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .audio_rst  (audio_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 refclk = ~refclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_failed=%0d", tests_failed);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge refclk) begin
    if (mon_en && (state_dbg !== prev_state)) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_state: got state %0d, required no transition", state_dbg);
      end else begin
        sb_exp = exp_q.pop_front();
        if (state_dbg !== sb_exp) begin
          tests_failed++;
          $display("FAIL sb_state: got state %0d, required %0d", state_dbg, sb_exp);
        end
      end
      prev_state = state_dbg;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  function automatic logic sig_of(input int sel);
    case (sel)
      SEL_PLL: return pll_rst;
      SEL_AUD: return audio_rst;
      SEL_RDY: return ready;
      SEL_FLT: return fault;
      default: return (state_dbg == 3'd2);
    endcase
  endfunction

  // Ticks until the selected signal equals val. n is the tick count, or
  // limit+1 if the bound expires.
  task automatic wait_for(input int sel, input logic val, input int limit, output int n);
    n = 0;
    while (n <= limit) begin
      tick();
      n++;
      if (sig_of(sel) === val) return;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    repeat (3) tick();
    tests_run += 6;
    if (pll_rst !== 1'b1)     begin tests_failed++; $display("FAIL rst_pll_rst: got %b, required 1", pll_rst); end
    if (audio_rst !== 1'b1)   begin tests_failed++; $display("FAIL rst_audio_rst: got %b, required 1", audio_rst); end
    if (ready !== 1'b0)       begin tests_failed++; $display("FAIL rst_ready: got %b, required 0", ready); end
    if (fault !== 1'b0)       begin tests_failed++; $display("FAIL rst_fault: got %b, required 0", fault); end
    if (retry_count !== 2'd0) begin tests_failed++; $display("FAIL rst_retry: got %0d, required 0", retry_count); end
    if (state_dbg !== 3'd0)   begin tests_failed++; $display("FAIL rst_state: got %0d, required 0", state_dbg); end
    prev_state = 3'd0;
    mon_en = 1'b1;
  endtask

  task automatic test_power_up_lock();
    int n;
    exp_q.push_back(3'd1);
    rst = 1'b0;
    wait_for(SEL_PLL, 1'b0, 20, n);
    tests_run++;
    if (n != RP) begin tests_failed++; $display("FAIL pu_pulse_width: got %0d, required %0d", n, RP); end
    repeat (5) tick();
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    pll_locked = 1'b1;
    wait_for(SEL_RDY, 1'b1, 40, n);
    tests_run += 4;
    if (n != LOCK_LAT)        begin tests_failed++; $display("FAIL pu_ready_latency: got %0d, required %0d", n, LOCK_LAT); end
    if (audio_rst !== 1'b0)   begin tests_failed++; $display("FAIL pu_audio_rst: got %b, required 0", audio_rst); end
    if (pll_rst !== 1'b0)     begin tests_failed++; $display("FAIL pu_pll_rst: got %b, required 0", pll_rst); end
    if (retry_count !== 2'd0) begin tests_failed++; $display("FAIL pu_retry: got %0d, required 0", retry_count); end
  endtask

  task automatic test_run_loss();
    int n;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    pll_locked = 1'b0;
    wait_for(SEL_AUD, 1'b1, 10, n);
    tests_run += 3;
    if (n != 3)             begin tests_failed++; $display("FAIL loss_latency: got %0d, required 3", n); end
    if (ready !== 1'b0)     begin tests_failed++; $display("FAIL loss_ready: got %b, required 0", ready); end
    if (pll_rst !== 1'b1)   begin tests_failed++; $display("FAIL loss_pll_rst: got %b, required 1", pll_rst); end
    wait_for(SEL_PLL, 1'b0, 10, n);
    tests_run++;
    if (n != RP) begin tests_failed++; $display("FAIL loss_pulse_width: got %0d, required %0d", n, RP); end
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    pll_locked = 1'b1;
    wait_for(SEL_RDY, 1'b1, 40, n);
    tests_run++;
    if (n != LOCK_LAT) begin tests_failed++; $display("FAIL loss_relock_latency: got %0d, required %0d", n, LOCK_LAT); end
  endtask

  task automatic test_timeout_fault();
    int n;
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(3'd0);
      exp_q.push_back(3'd1);
    end
    exp_q.push_back(3'd4);
    pll_locked = 1'b0;
    wait_for(SEL_PLL, 1'b1, 10, n);
    tests_run++;
    if (n != 3) begin tests_failed++; $display("FAIL to_first_pulse: got %0d, required 3", n); end
    for (int p = 0; p < 3; p++) begin
      wait_for(SEL_PLL, 1'b0, 10, n);
      tests_run += 2;
      if (n != RP) begin tests_failed++; $display("FAIL to_pulse_width[%0d]: got %0d, required %0d", p, n, RP); end
      if (retry_count !== 2'(p)) begin tests_failed++; $display("FAIL to_retry[%0d]: got %0d, required %0d", p, retry_count, p); end
      wait_for(SEL_PLL, 1'b1, LT + 5, n);
      tests_run++;
      if (n != LT) begin tests_failed++; $display("FAIL to_spacing[%0d]: got %0d, required %0d", p, n, LT); end
    end
    tests_run += 4;
    if (fault !== 1'b1)       begin tests_failed++; $display("FAIL to_fault: got %b, required 1", fault); end
    if (state_dbg !== 3'd4)   begin tests_failed++; $display("FAIL to_state: got %0d, required 4", state_dbg); end
    if (retry_count !== 2'd2) begin tests_failed++; $display("FAIL to_retry_final: got %0d, required 2", retry_count); end
    if (audio_rst !== 1'b1)   begin tests_failed++; $display("FAIL to_audio_rst: got %b, required 1", audio_rst); end
    // Lock activity while faulted must not leave FAULT.
    pll_locked = 1'b1;
    repeat (6) tick();
    pll_locked = 1'b0;
    repeat (4) tick();
    tests_run += 2;
    if (fault !== 1'b1)     begin tests_failed++; $display("FAIL fault_sticky: got %b, required 1", fault); end
    if (pll_rst !== 1'b1)   begin tests_failed++; $display("FAIL fault_pll_rst: got %b, required 1", pll_rst); end
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    tests_run += 4;
    if (fault !== 1'b0)       begin tests_failed++; $display("FAIL clr_fault: got %b, required 0", fault); end
    if (retry_count !== 2'd0) begin tests_failed++; $display("FAIL clr_retry: got %0d, required 0", retry_count); end
    if (pll_rst !== 1'b1)     begin tests_failed++; $display("FAIL clr_pll_rst: got %b, required 1", pll_rst); end
    if (state_dbg !== 3'd0)   begin tests_failed++; $display("FAIL clr_state: got %0d, required 0", state_dbg); end
    wait_for(SEL_PLL, 1'b0, 10, n);
    tests_run++;
    if (n != RP) begin tests_failed++; $display("FAIL clr_pulse_width: got %0d, required %0d", n, RP); end
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    pll_locked = 1'b1;
    wait_for(SEL_RDY, 1'b1, 40, n);
    tests_run++;
    if (n != LOCK_LAT) begin tests_failed++; $display("FAIL clr_ready_latency: got %0d, required %0d", n, LOCK_LAT); end
  endtask

  task automatic test_stabilize_glitch();
    int n;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    wait_for(SEL_STAB, 1'b1, 20, n);
    tests_run++;
    if (n != RP + 1) begin tests_failed++; $display("FAIL gl_reach_stab: got %0d, required %0d", n, RP + 1); end
    // The drop reaches the FSM when its stable count is 5.
    repeat (3) tick();
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_for(SEL_RDY, 1'b1, 40, n);
    tests_run += 2;
    if (n != LOCK_LAT)        begin tests_failed++; $display("FAIL gl_ready_latency: got %0d, required %0d", n, LOCK_LAT); end
    if (retry_count !== 2'd0) begin tests_failed++; $display("FAIL gl_retry: got %0d, required 0", retry_count); end
  endtask

  task automatic test_relock_combined();
    int n;
    pll_locked = 1'b0;
    tick();
    tick();
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    tests_run += 3;
    if (state_dbg !== 3'd0) begin tests_failed++; $display("FAIL comb_state: got %0d, required 0", state_dbg); end
    if (ready !== 1'b0)     begin tests_failed++; $display("FAIL comb_ready: got %b, required 0", ready); end
    if (audio_rst !== 1'b1) begin tests_failed++; $display("FAIL comb_audio_rst: got %b, required 1", audio_rst); end
    wait_for(SEL_PLL, 1'b0, 10, n);
    tests_run++;
    if (n != RP) begin tests_failed++; $display("FAIL comb_pulse_width: got %0d, required %0d", n, RP); end
    repeat (3) tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    tests_run += 2;
    if (state_dbg !== 3'd1) begin tests_failed++; $display("FAIL comb_ign_wait_state: got %0d, required 1", state_dbg); end
    if (pll_rst !== 1'b0)   begin tests_failed++; $display("FAIL comb_ign_wait_pll_rst: got %b, required 0", pll_rst); end
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    pll_locked = 1'b1;
    repeat (5) tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    wait_for(SEL_RDY, 1'b1, 20, n);
    tests_run++;
    if (n + 6 != LOCK_LAT) begin tests_failed++; $display("FAIL comb_ign_stab_latency: got %0d, required %0d", n + 6, LOCK_LAT); end
  endtask

  task automatic test_async_reset();
    int n;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    wait_for(SEL_STAB, 1'b1, 20, n);
    tests_run++;
    if (n != RP + 1) begin tests_failed++; $display("FAIL ar_reach_stab: got %0d, required %0d", n, RP + 1); end
    tick();
    tick();
    // Assert reset mid-cycle, then sample before the next refclk edge.
    #2;
    exp_q.push_back(3'd0);
    rst = 1'b1;
    #1;
    tests_run += 4;
    if (pll_rst !== 1'b1)   begin tests_failed++; $display("FAIL ar_pll_rst: got %b, required 1", pll_rst); end
    if (audio_rst !== 1'b1) begin tests_failed++; $display("FAIL ar_audio_rst: got %b, required 1", audio_rst); end
    if (ready !== 1'b0)     begin tests_failed++; $display("FAIL ar_ready: got %b, required 0", ready); end
    if (state_dbg !== 3'd0) begin tests_failed++; $display("FAIL ar_state: got %0d, required 0", state_dbg); end
    tick();
    tick();
    exp_q.push_back(3'd1);
    rst = 1'b0;
    wait_for(SEL_PLL, 1'b0, 10, n);
    tests_run++;
    if (n != RP) begin tests_failed++; $display("FAIL ar_pulse_width: got %0d, required %0d", n, RP); end
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    wait_for(SEL_RDY, 1'b1, 20, n);
    tests_run++;
    if (n != LS + 1) begin tests_failed++; $display("FAIL ar_ready_latency: got %0d, required %0d", n, LS + 1); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_power_up_lock();
    test_run_loss();
    test_timeout_fault();
    test_stabilize_glitch();
    test_relock_combined();
    test_async_reset();
    repeat (3) tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d pending transitions, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/audio_pll_lock_sequencer.md
Name: audio_pll_lock_sequencer

Overview:
- Supervises the audio PLL (50 MHz reference in, 12.288 MHz audio clock out) from the reference-clock domain.
- Sequences the PLL reset pulse, waits for a stable lock and only then releases the reset of the audio-clock logic.
- Retries on lock timeout and raises a sticky fault after repeated failures.
- Re-sequences on loss of lock or on a software relock request.

Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles that pll_rst is held high per attempt (>=1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before ready (>=1).
- LOCK_TIMEOUT_CYCLES, 65536: refclk cycles allowed in WAIT_LOCK per attempt (>=2).
- MAX_RETRIES, 3: retries after the first attempt before FAULT (1..3).
- CNT_W, 17: shared counter width; must hold max(all three cycle parameters).

Ports:
- refclk  in  1  reference clock (50 MHz); the only clock.
- rst  in  1  reset, asynchronous, active-high.
- pll_locked  in  1  PLL locked, asynchronous to refclk.
- relock_req  in  1  single-cycle relock/fault-clear request.
- pll_rst  out  1  reset to the PLL.
- audio_rst  out  1  reset for the audio-clock logic; the consumer synchronizes deassertion.
- ready  out  1  high while in RUN.
- fault  out  1  high while in FAULT.
- retry_count  out  2  retries used in the current sequence.
- state_dbg  out  3  encoded state: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4.

Behaviour:
- All outputs are registered.
- pll_locked passes through a 2-flop synchronizer (reset value 0) to form lk. All decisions use lk, so response latency to the raw input is 2 cycles.
- Reset values: state RESET_PLL, cnt 0, pll_rst 1, audio_rst 1, ready 0, fault 0, retry_count 0, synchronizer 0.
- Outputs by state:
  - RESET_PLL: pll_rst 1, audio_rst 1.
  - WAIT_LOCK / STABILIZE: pll_rst 0, audio_rst 1.
  - RUN: pll_rst 0, audio_rst 0, ready 1.
  - FAULT: pll_rst 1, audio_rst 1, fault 1.
- RESET_PLL: cnt increments each cycle. When cnt==RST_PULSE_CYCLES-1, go to WAIT_LOCK and clear cnt. pll_rst is therefore high for exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK:
  - lk=1: go to STABILIZE, cnt 0.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1 and retry_count<MAX_RETRIES: retry_count+1, go to RESET_PLL, cnt 0.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1 and retry_count==MAX_RETRIES: go to FAULT.
  - lk=1 on the timeout cycle: lock wins.
- STABILIZE: cnt counts consecutive lk=1 cycles.
  - lk=0: go to WAIT_LOCK with cnt 0. This restarts the timeout window; retry_count is unchanged.
  - cnt==LOCK_STABLE_CYCLES-1 with lk=1: go to RUN. ready and audio_rst=0 appear the following cycle (registered).
- RUN:
  - lk=0: go to RESET_PLL next cycle, with retry_count 0, ready 0, audio_rst 1.
  - relock_req=1: same transition. Simultaneous lk=0 and relock_req give the identical result.
- FAULT: sticky. relock_req=1 clears fault, sets retry_count 0 and goes to RESET_PLL. pll_locked activity is ignored.
- relock_req is ignored in RESET_PLL, WAIT_LOCK and STABILIZE.
- Async rst mid-operation forces reset values immediately, regardless of the clock. The first RESET_PLL pulse starts on the first refclk edge after rst deasserts.
- Counters never wrap; every terminal compare clears cnt on transition.
- Only one transition occurs per cycle.

Test Plan (RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2):
1. Release rst; raise pll_locked 5 cycles after pll_rst falls. Required: pll_rst high 4 cycles; ready=1, audio_rst=0 exactly 2+8+1 cycles after pll_locked rises; retry_count=0.
2. pll_locked held 0. Required: exactly 3 pll_rst pulses of 4 cycles each, spaced 32 cycles apart; retry_count steps 1 then 2; fault=1 after the third timeout; pll_rst stays 1. Then pulse relock_req. Required: fault=0, retry_count=0, new 4-cycle sequence starts.
3. In STABILIZE, drop pll_locked for 1 cycle at stable count 5. Required: return to WAIT_LOCK, ready stays 0; after lock returns, ready needs a full 8 consecutive cycles; retry_count unchanged.
4. In RUN, drop pll_locked. Required: audio_rst=1 and ready=0 exactly 3 cycles later; pll_rst pulse follows; full relock sequence completes.
5. In RUN, pulse relock_req together with a pll_locked drop. Required: single RESET_PLL entry; relock_req pulses in WAIT_LOCK/STABILIZE have no effect.
6. Assert rst asynchronously mid-STABILIZE between clock edges. Required: pll_rst=1, audio_rst=1, ready=0, state_dbg=0 before the next refclk edge.
